cmd_sndr: RTL and testbench

Host-side command transmitter: the sending end of the 16-bit command link consumed by the follower's command processor. On a one-cycle `snd_cmd` request it captures a 16-bit command and serializes it on `TX` as two back-to-back 8N1 UART frames, high byte first, using an internal baud counter and shift register. Completion is reported on `cmd_snt`, which stays high until the next accepted request. It sits in the remote/test-harness side of the design, driving the robot's `RX` pin.

---
 rtl/cmd_sndr.sv | 81 ++++++++
 tb/tb_cmd_sndr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cmd_sndr.sv
// Host-side 16-bit command transmitter: sends a captured word as two back-to-back
// 8N1 UART frames on TX, high byte first.
module cmd_sndr #(
    parameter int unsigned BAUD_CNT = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    output logic        TX,
    output logic        cmd_snt,
    output logic        tx_busy
);

    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;

    localparam logic [11:0] BaudLast = 12'(BAUD_CNT - 1);

    state_t      state;
    logic [11:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [9:0]  shifter;
    logic [7:0]  lo_byte;

    // TX always mirrors shifter[0]; it is registered separately so the line is
    // glitch-free and forced high by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= '1;
            lo_byte  <= '0;
            TX       <= 1'b1;
            cmd_snt  <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (snd_cmd) begin
                        shifter  <= {1'b1, cmd[15:8], 1'b0};
                        lo_byte  <= cmd[7:0];
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        TX       <= 1'b0;
                        cmd_snt  <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= SEND_HI;
                    end
                end
                SEND_HI, SEND_LO: begin
                    if (baud_cnt == BaudLast) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            bit_cnt <= '0;
                            if (state == SEND_HI) begin
                                // Start bit of the low byte follows the stop bit with no gap.
                                shifter <= {1'b1, lo_byte, 1'b0};
                                TX      <= 1'b0;
                                state   <= SEND_LO;
                            end else begin
                                TX      <= 1'b1;
                                cmd_snt <= 1'b1;
                                tx_busy <= 1'b0;
                                state   <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shifter <= {1'b1, shifter[9:1]};
                            TX      <= shifter[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sndr.sv
// Bench for cmd_sndr: time-based line model checked every cycle, plus directed
// mid-bit samples and latency checks against hand-computed values.
module tb_cmd_sndr;

    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        TX, cmd_snt, tx_busy;

    int pass_cnt = 0;
    int tot_cnt = 0;
    int acc_q[$];

    cmd_sndr #(.BAUD_CNT(B)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .snd_cmd(snd_cmd),
        .cmd    (cmd),
        .TX     (TX),
        .cmd_snt(cmd_snt),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Inputs as seen by the DUT at the last rising edge.
    logic        s_snd = 1'b0;
    logic        s_rst = 1'b0;
    logic [15:0] s_cmd = 16'h0;
    always @(posedge clk) begin
        s_snd <= snd_cmd;
        s_cmd <= cmd;
        s_rst <= rst_n;
    end

    // Model: a transmission is an accept time plus a word; the line value is the
    // bit whose period contains the current cycle.
    initial begin
        int          cyc = 0;
        bit          m_busy = 0;
        bit          m_snt = 0;
        int          m_e0 = 0;
        logic [15:0] m_word = 16'h0;
        logic [19:0] fr;
        logic        exp_tx;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n || !s_rst) begin
                m_busy = 0;
                m_snt  = 0;
            end else if (m_busy) begin
                if (cyc - m_e0 == 20 * B) begin
                    m_busy = 0;
                    m_snt  = 1;
                end
            end else if (s_snd) begin
                m_busy = 1;
                m_snt  = 0;
                m_e0   = cyc;
                m_word = s_cmd;
                acc_q.push_back(cyc);
            end
            fr = {1'b1, m_word[7:0], 1'b0, 1'b1, m_word[15:8], 1'b0};
            exp_tx = m_busy ? fr[(cyc - m_e0) / B] : 1'b1;
            check("model_tx", 32'(TX), 32'(exp_tx));
            check("model_busy", 32'(tx_busy), 32'(m_busy));
            check("model_snt", 32'(cmd_snt), 32'(m_snt));
        end
    end

    // Request a send from idle, sample TX at every mid-bit, and time cmd_snt.
    task automatic send_check(input logic [15:0] w, input logic [19:0] bits);
        int n = 0;
        bit got = 0;
        @(posedge clk); #1;
        snd_cmd = 1'b1;
        cmd = w;
        @(posedge clk); #1;
        snd_cmd = 1'b0;
        check("e0_tx", 32'(TX), 32'd0);
        check("e0_busy", 32'(tx_busy), 32'd1);
        check("e0_snt", 32'(cmd_snt), 32'd0);
        while (n < 400 && !got) begin
            @(posedge clk); #1;
            n++;
            if (n % B == B / 2 && n < 20 * B) check("midbit", 32'(TX), 32'(bits[n / B]));
            if (cmd_snt) got = 1;
        end
        check("snt_latency", 32'(n), 32'd320);
        check("end_busy", 32'(tx_busy), 32'd0);
        check("end_tx", 32'(TX), 32'd1);
    endtask

    initial begin
        int a0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_snt", 32'(cmd_snt), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        repeat (100) @(posedge clk);
        #1 check("idle_tx", 32'(TX), 32'd1);
        check("idle_busy", 32'(tx_busy), 32'd0);

        send_check(16'hA53C, 20'b1_00111100_0_1_10100101_0);
        send_check(16'h0003, 20'b1_00000011_0_1_00000000_0);
        send_check(16'hFFFF, 20'b1_11111111_0_1_11111111_0);

        // Requests while busy must be dropped.
        a0 = acc_q.size();
        @(posedge clk); #1;
        snd_cmd = 1'b1;
        cmd = 16'h1234;
        @(posedge clk); #1;
        snd_cmd = 1'b0;
        for (int n = 1; n <= 330; n++) begin
            @(posedge clk); #1;
            if (n == 4 || n == 159 || n == 318) begin
                snd_cmd = 1'b1;
                cmd = 16'hFFFF;
            end else begin
                snd_cmd = 1'b0;
            end
        end
        check("busy_accepts", 32'(acc_q.size() - a0), 32'd1);
        check("busy_snt", 32'(cmd_snt), 32'd1);

        // Continuous request: one acceptance per 20*B+1 cycles.
        a0 = acc_q.size();
        @(posedge clk); #1;
        snd_cmd = 1'b1;
        cmd = 16'h8001;
        repeat (700) @(posedge clk);
        #1 snd_cmd = 1'b0;
        check("b2b_accepts", 32'(acc_q.size() - a0), 32'd3);
        if (acc_q.size() - a0 >= 3) begin
            check("b2b_gap1", 32'(acc_q[a0 + 1] - acc_q[a0]), 32'd321);
            check("b2b_gap2", 32'(acc_q[a0 + 2] - acc_q[a0 + 1]), 32'd321);
        end
        repeat (330) @(posedge clk);

        // Reset mid-frame abandons the transmission.
        @(posedge clk); #1;
        snd_cmd = 1'b1;
        cmd = 16'h5A0F;
        @(posedge clk); #1;
        snd_cmd = 1'b0;
        repeat (170) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("mid_rst_tx", 32'(TX), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_snt", 32'(cmd_snt), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        send_check(16'h00FF, 20'b1_11111111_0_1_00000000_0);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
